// File: rtl/router_pkg.sv
// Shared types for the router node: output port classes, port FSM states
// and the destination-to-port classification helper.
package router_pkg;

  localparam int NUM_PORTS = 4;

  typedef enum logic [1:0] {
    PORT_SELF = 2'd0,
    PORT_NS   = 2'd1,
    PORT_WE   = 2'd2,
    PORT_DIAG = 2'd3
  } port_e;

  typedef enum logic [0:0] {
    P_IDLE = 1'b0,
    P_BUSY = 1'b1
  } port_state_e;

  // x_hit/y_hit: destination coordinate equals this node's coordinate
  function automatic port_e route_class(input logic x_hit, input logic y_hit);
    port_e r;
    case ({x_hit, y_hit})
      2'b11:   r = PORT_SELF;
      2'b10:   r = PORT_NS;
      2'b01:   r = PORT_WE;
      default: r = PORT_DIAG;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester strictly after ptr, wrapping.
// The pointer itself is owned by the caller.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan offsets 1..N from ptr so ptr itself has lowest priority
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    if (en) begin
      for (int off = 1; off <= N; off++) begin
        j = (int'(ptr) + off) % N;
        if (!any && req[j]) begin
          any    = 1'b1;
          gnt[j] = 1'b1;
          idx    = IW'(j);
        end else begin
          any = any;
        end
      end
    end else begin
      any = 1'b0;
    end
  end

endmodule

// File: rtl/router_route_arb.sv
// Route compute and per-output-port round-robin arbitration for one mesh node.
// A port is held by its owner until the owner's last flit or until it drops req.
module router_route_arb
  import router_pkg::*;
#(
  parameter int NUM_IN = 4,
  parameter int XW     = 2,
  parameter int YW     = 2,
  parameter int MAXX   = 3,
  parameter int MAXY   = 3,
  parameter int SELFX  = 1,
  parameter int SELFY  = 1,
  localparam int IDXW  = $clog2(NUM_IN)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [NUM_IN-1:0]         req_i,
  input  logic [NUM_IN*XW-1:0]      dst_x_i,
  input  logic [NUM_IN*YW-1:0]      dst_y_i,
  input  logic [NUM_IN-1:0]         last_i,
  output logic [NUM_IN-1:0]         gnt_o,
  output logic [NUM_IN*2-1:0]       route_o,
  output logic [NUM_PORTS-1:0]      port_busy_o,
  output logic [NUM_PORTS*IDXW-1:0] port_owner_o,
  output logic [NUM_IN-1:0]         err_o
);

  localparam logic [XW-1:0] SELFX_L = XW'(SELFX);
  localparam logic [YW-1:0] SELFY_L = YW'(SELFY);
  localparam logic [XW-1:0] MAXX_L  = XW'(MAXX);
  localparam logic [YW-1:0] MAXY_L  = YW'(MAXY);

  port_e             route_s   [NUM_IN];
  logic [NUM_IN-1:0] valid_s;
  logic [NUM_IN-1:0] inv_req_s;
  logic [NUM_IN-1:0] granted_s;
  logic [NUM_IN-1:0] cand_s    [NUM_PORTS];
  logic [NUM_IN-1:0] pick_gnt_s[NUM_PORTS];
  logic [IDXW-1:0]   pick_idx_s[NUM_PORTS];
  logic [NUM_PORTS-1:0] pick_any_s;
  logic [NUM_PORTS-1:0] arb_en_s;

  port_state_e     state_r[NUM_PORTS];
  port_state_e     state_s[NUM_PORTS];
  logic [IDXW-1:0] owner_r[NUM_PORTS];
  logic [IDXW-1:0] owner_s[NUM_PORTS];
  logic [IDXW-1:0] ptr_r  [NUM_PORTS];
  logic [IDXW-1:0] ptr_s  [NUM_PORTS];

  logic [NUM_IN-1:0]         gnt_s, gnt_r;
  logic [NUM_IN*2-1:0]       route_nx_s, route_r;
  logic [NUM_PORTS-1:0]      busy_s, busy_r;
  logic [NUM_PORTS*IDXW-1:0] owner_out_s, owner_out_r;
  logic [NUM_IN-1:0]         err_r, inv_prev_r;

  // Classify each destination and flag out-of-mesh requests
  always_comb begin
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    x = '0;
    y = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      x            = dst_x_i[i*XW +: XW];
      y            = dst_y_i[i*YW +: YW];
      route_s[i]   = route_class(x == SELFX_L, y == SELFY_L);
      valid_s[i]   = !((x > MAXX_L) || (y > MAXY_L));
      inv_req_s[i] = req_i[i] & ~valid_s[i];
    end
  end

  // An input already owning any port is not a candidate anywhere else
  always_comb begin
    granted_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (state_r[p] == P_BUSY) begin
        granted_s[owner_r[p]] = 1'b1;
      end else begin
        granted_s = granted_s;
      end
    end
    for (int p = 0; p < NUM_PORTS; p++) begin
      arb_en_s[p] = (state_r[p] == P_IDLE);
      for (int i = 0; i < NUM_IN; i++) begin
        cand_s[p][i] = req_i[i] & valid_s[i] & ~granted_s[i] &
                       (route_s[i] == port_e'(p));
      end
    end
  end

  for (genvar gp = 0; gp < NUM_PORTS; gp++) begin : g_arb
    rr_arbiter #(.N(NUM_IN), .IW(IDXW)) u_rr_arbiter (
      .req (cand_s[gp]),
      .ptr (ptr_r[gp]),
      .en  (arb_en_s[gp]),
      .gnt (pick_gnt_s[gp]),
      .idx (pick_idx_s[gp]),
      .any (pick_any_s[gp])
    );
  end

  // Port FSMs and the next-cycle view of grants, routes and ownership
  always_comb begin
    gnt_s       = '0;
    route_nx_s  = '0;
    busy_s      = '0;
    owner_out_s = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      state_s[p] = state_r[p];
      owner_s[p] = owner_r[p];
      ptr_s[p]   = ptr_r[p];
      case (state_r[p])
        P_IDLE: begin
          if (pick_any_s[p]) begin
            state_s[p] = P_BUSY;
            owner_s[p] = pick_idx_s[p];
            gnt_s      = gnt_s | pick_gnt_s[p];
          end else begin
            state_s[p] = P_IDLE;
          end
        end
        P_BUSY: begin
          if (!req_i[owner_r[p]] || last_i[owner_r[p]]) begin
            state_s[p] = P_IDLE;
            ptr_s[p]   = owner_r[p];
          end else begin
            state_s[p]            = P_BUSY;
            gnt_s[owner_r[p]]     = 1'b1;
          end
        end
        default: begin
          state_s[p] = P_IDLE;
          owner_s[p] = '0;
        end
      endcase
      if (state_s[p] == P_BUSY) begin
        route_nx_s[int'(owner_s[p])*2 +: 2] = 2'(p);
        busy_s[p]                           = 1'b1;
        owner_out_s[p*IDXW +: IDXW]         = owner_s[p];
      end else begin
        busy_s[p] = 1'b0;
      end
    end
  end

  // State and registered outputs; reset drops every grant at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_r[p] <= P_IDLE;
        owner_r[p] <= '0;
        ptr_r[p]   <= IDXW'(NUM_IN - 1);
      end
      gnt_r       <= '0;
      route_r     <= '0;
      busy_r      <= '0;
      owner_out_r <= '0;
      err_r       <= '0;
      inv_prev_r  <= '0;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        state_r[p] <= state_s[p];
        owner_r[p] <= owner_s[p];
        ptr_r[p]   <= ptr_s[p];
      end
      gnt_r       <= gnt_s;
      route_r     <= route_nx_s;
      busy_r      <= busy_s;
      owner_out_r <= owner_out_s;
      err_r       <= inv_req_s & ~inv_prev_r;
      inv_prev_r  <= inv_req_s;
    end
  end

  assign gnt_o        = gnt_r;
  assign route_o      = route_r;
  assign port_busy_o  = busy_r;
  assign port_owner_o = owner_out_r;
  assign err_o        = err_r;

endmodule

// File: tb/tb_router_route_arb.sv
// Directed bench for router_route_arb: default mesh instance plus a MAXX=1
// instance for the out-of-range destination case.
module tb_router_route_arb;
  import router_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [3:0] req, last, gnt, busy, err;
  logic [7:0] dx, dy, route, owner;
  logic [3:0] req1, last1, gnt1, busy1, err1;
  logic [7:0] dx1, dy1, route1, owner1;

  int checks = 0;
  int passed = 0;
  int fails  = 0;

  router_route_arb u_dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .dst_x_i(dx), .dst_y_i(dy),
    .last_i(last), .gnt_o(gnt), .route_o(route), .port_busy_o(busy),
    .port_owner_o(owner), .err_o(err)
  );

  router_route_arb #(.MAXX(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req1), .dst_x_i(dx1), .dst_y_i(dy1),
    .last_i(last1), .gnt_o(gnt1), .route_o(route1), .port_busy_o(busy1),
    .port_owner_o(owner1), .err_o(err1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dst(input int i, input int x, input int y);
    dx[i*2 +: 2] = 2'(x);
    dy[i*2 +: 2] = 2'(y);
  endtask

  initial begin
    int         cnt[4];
    logic [3:0] pg;
    logic [3:0] exp_g;

    req = 4'b0; last = 4'b0; dx = 8'h00; dy = 8'h00;
    req1 = 4'b0; last1 = 4'b0; dx1 = 8'h00; dy1 = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_route", 32'(route), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    rst_n = 1'b1;
    step();

    // 1: single-flit packet to SELF
    set_dst(0, 1, 1);
    req = 4'b0001; last = 4'b0001;
    step();
    check("t1_gnt", 32'(gnt), 32'h1);
    check("t1_busy", 32'(busy), 32'h1);
    check("t1_route", 32'(route), 32'h0);
    step();
    check("t1_release_gnt", 32'(gnt), 32'h0);
    check("t1_release_busy", 32'(busy), 32'h0);
    req = 4'b0; last = 4'b0;
    step();

    // 2: three ports granted in the same cycle
    set_dst(1, 1, 3); set_dst(2, 3, 1); set_dst(3, 0, 0);
    req = 4'b1110;
    step();
    check("t2_gnt", 32'(gnt), 32'he);
    check("t2_route", 32'(route), 32'he4);
    check("t2_busy", 32'(busy), 32'he);
    check("t2_owner", 32'(owner), 32'he4);
    step();
    check("t2_hold", 32'(gnt), 32'he);
    last = 4'b1110;
    step();
    check("t2_release", 32'(gnt), 32'h0);
    req = 4'b0; last = 4'b0;
    step();

    // 3: four 3-flit packets contending for DIAG, then wrap to input 0
    for (int i = 0; i < 4; i++) begin
      set_dst(i, 2, 2);
      cnt[i] = 0;
    end
    pg  = 4'b0;
    req = 4'b1111;
    for (int k = 1; k <= 17; k++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (pg[i]) cnt[i] = (cnt[i] == 2) ? 0 : cnt[i] + 1;
      end
      exp_g = (k % 4 == 0) ? 4'b0000 : (4'b0001 << (((k - 1) / 4) % 4));
      check($sformatf("t3_gnt_k%0d", k), 32'(gnt), 32'(exp_g));
      last = 4'b0;
      for (int i = 0; i < 4; i++) begin
        if (gnt[i] && cnt[i] == 2) last[i] = 1'b1;
      end
      pg = gnt;
    end
    req = 4'b0; last = 4'b0;
    step();
    check("t3_drop_release", 32'(gnt), 32'h0);
    step();

    // 4: owner changes destination mid-packet
    set_dst(1, 1, 3);
    req = 4'b0010;
    step();
    check("t4_gnt", 32'(gnt), 32'h2);
    check("t4_route", 32'(route), 32'h04);
    set_dst(1, 3, 3);
    step();
    check("t4_route_held", 32'(route), 32'h04);
    check("t4_busy_ns", 32'(busy), 32'h2);
    step();
    check("t4_gnt_held", 32'(gnt), 32'h2);
    last = 4'b0010;
    step();
    check("t4_release", 32'(gnt), 32'h0);
    req = 4'b0; last = 4'b0;
    step();
    check("t4_no_diag_gnt", 32'(gnt), 32'h0);
    check("t4_no_diag_busy", 32'(busy), 32'h0);

    // 5: out-of-range destination on the MAXX=1 instance
    dx1 = 8'h20; dy1 = 8'h00;
    req1 = 4'b0101;
    step();
    check("t5_err_pulse", 32'(err1), 32'h4);
    check("t5_gnt_valid_only", 32'(gnt1), 32'h1);
    step();
    check("t5_err_single", 32'(err1), 32'h0);
    step();
    check("t5_never_gnt", 32'(gnt1), 32'h1);
    req1 = 4'b0;
    step();
    check("t5_err_quiet", 32'(err1), 32'h0);

    // 6: async reset with two ports busy, then input 0 wins re-arbitration
    set_dst(1, 1, 3); set_dst(2, 3, 1);
    req = 4'b0110;
    step();
    check("t6_pre_gnt", 32'(gnt), 32'h6);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_gnt", 32'(gnt), 32'h0);
    check("t6_rst_route", 32'(route), 32'h0);
    check("t6_rst_busy", 32'(busy), 32'h0);
    check("t6_rst_owner", 32'(owner), 32'h0);
    for (int i = 0; i < 4; i++) set_dst(i, 2, 2);
    req = 4'b1111;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t6_rearb_gnt", 32'(gnt), 32'h1);
    check("t6_rearb_route", 32'(route), 32'h03);
    check("t6_rearb_busy", 32'(busy), 32'h8);
    req = 4'b0;
    step();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
